// File: rtl/vram_arbiter_if.sv
// CPU-side request/ack bundle for the video RAM arbiter.
// The requester holds cpu_we/cpu_addr/cpu_wdata stable while cpu_req is high.
interface vram_arbiter_if #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 8
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_BITS-1:0] cpu_addr;
  logic [DATA_BITS-1:0] cpu_wdata;
  logic                 cpu_ack;
  logic [DATA_BITS-1:0] cpu_rdata;

  modport master (
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    input  cpu_ack,
    input  cpu_rdata
  );

  modport slave (
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    output cpu_ack,
    output cpu_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: raster read slot plus CPU req/ack port.
// Define VRAM_CLEAR_EN to build the screen-clear sequencer.
module vram_arbiter #(
  parameter int                   ADDR_BITS = 10,
  parameter int                   DATA_BITS = 8,
  parameter int                   VID_SLOT  = 6,
  parameter logic [DATA_BITS-1:0] CLEAR_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8:0]           hpos,
  input  logic [ADDR_BITS-1:0] vid_addr,
  output logic [DATA_BITS-1:0] vid_data,
  vram_arbiter_if.slave        cpu,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_din,
  output logic                 ram_we,
  input  logic [DATA_BITS-1:0] ram_dout,
  input  logic                 clear_start,
  output logic                 clear_busy
);

  localparam logic [2:0] SlotPos = 3'(VID_SLOT);
  localparam logic [2:0] CapPos  = SlotPos + 3'd1;

`ifdef VRAM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, WAIT, ACK, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
`endif

  state_t               state_q;
  logic [DATA_BITS-1:0] vid_data_q;
  logic                 ack_q;
  logic [DATA_BITS-1:0] rdata_q;
  logic                 we_q;
  logic                 vid_slot;
  logic                 vid_cap;
  logic                 clr_pend;
  logic                 grant;

  assign vid_slot = (hpos[2:0] == SlotPos);
  assign vid_cap  = (hpos[2:0] == CapPos);

`ifdef VRAM_CLEAR_EN
  logic                 pend_q;
  logic                 busy_q;
  logic [ADDR_BITS-1:0] cnt_q;
  logic                 unused_x;

  assign clr_pend   = pend_q;
  assign clear_busy = busy_q;
  assign unused_x   = ^hpos[8:3];
`else
  logic unused_x;

  assign clr_pend   = 1'b0;
  assign clear_busy = 1'b0;
  assign unused_x   = ^{hpos[8:3], clear_start, CLEAR_VAL};
`endif

  assign grant = (state_q == IDLE) && cpu.cpu_req
              && !vid_slot && !clr_pend;

  assign vid_data      = vid_data_q;
  assign cpu.cpu_ack   = ack_q;
  assign cpu.cpu_rdata = rdata_q;

  // RAM drive is combinational so the grant cycle hits the RAM directly.
  always_comb begin
    ram_addr = vid_addr;
    ram_din  = cpu.cpu_wdata;
    ram_we   = 1'b0;
    if (!reset && !vid_slot) begin
      if (grant) begin
        ram_addr = cpu.cpu_addr;
        ram_we   = cpu.cpu_we;
      end
`ifdef VRAM_CLEAR_EN
      if (state_q == CLEAR) begin
        ram_addr = cnt_q;
        ram_din  = CLEAR_VAL;
        ram_we   = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      vid_data_q <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      we_q       <= 1'b0;
`ifdef VRAM_CLEAR_EN
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
`endif
    end else begin
      if (vid_cap) vid_data_q <= ram_dout;
      ack_q <= 1'b0;
`ifdef VRAM_CLEAR_EN
      if (clear_start && !pend_q && !busy_q)
        pend_q <= 1'b1;
`endif
      unique case (state_q)
        IDLE: begin
`ifdef VRAM_CLEAR_EN
          if (pend_q) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end else
`endif
          if (grant) begin
            state_q <= WAIT;
            we_q    <= cpu.cpu_we;
          end
        end
        WAIT: begin
          if (!we_q) rdata_q <= ram_dout;
          ack_q   <= 1'b1;
          state_q <= ACK;
        end
        ACK: state_q <= IDLE;
`ifdef VRAM_CLEAR_EN
        CLEAR: begin
          if (!vid_slot) begin
            cnt_q <= cnt_q + 1'b1;
            if (&cnt_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              pend_q  <= 1'b0;
            end
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
